// File: rtl/uart_rx_if.sv
// uart_rx_if: received-word handshake between the UART receiver and its byte consumer
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 valid;
    logic                 ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;
    modport master (output data_out, valid, parity_err, frame_err, overrun, busy, input ready);
    modport slave  (input data_out, valid, parity_err, frame_err, overrun, busy, output ready);
endinterface

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampling UART receiver with majority vote, parity/stop checks and valid/ready output
module uart_rx_oversample #(
    parameter int CLK_DIV    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int M  = OVERSAMPLE / 2;
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int PW = $clog2(OVERSAMPLE);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic                 s1, rx_s;
    logic [1:0]           primed;
    logic                 armed;
    logic [DW-1:0]        div;
    logic [PW-1:0]        phase;
    logic [3:0]           cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 smp_a, smp_b, par_bit, ferr_pend;
    logic                 tick, wrap, decide, maj, pe, fe;

    assign tick    = div == DW'(CLK_DIV - 1);
    assign wrap    = tick && phase == PW'(OVERSAMPLE - 1);
    assign decide  = tick && phase == PW'(M + 1);
    assign maj     = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
    assign bus.busy = state != IDLE;

    // parity verdict on the assembled word and frame-error verdict at the current stop-bit decision
    always_comb begin
        pe = PARITY == 0 ? 1'b0 : PARITY == 1 ? (par_bit != ^shreg) : (par_bit != ~^shreg);
        fe = ferr_pend | ~maj;
    end

    // two-flop synchroniser; primed marks when rx_s carries a real line sample rather than its reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= 1'b1;
            rx_s   <= 1'b1;
            primed <= 2'b00;
        end else begin
            s1     <= rx;
            rx_s   <= s1;
            primed <= {primed[0], 1'b1};
        end
    end

    // frame FSM with tick divider, bit-phase counter, voting and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            armed          <= 1'b0;
            div            <= '0;
            phase          <= '0;
            cnt            <= '0;
            shreg          <= '0;
            smp_a          <= 1'b0;
            smp_b          <= 1'b0;
            par_bit        <= 1'b0;
            ferr_pend      <= 1'b0;
            bus.data_out   <= '0;
            bus.valid      <= 1'b0;
            bus.parity_err <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            if (bus.valid && bus.ready) begin
                bus.valid      <= 1'b0;
                bus.overrun    <= 1'b0;
                bus.parity_err <= 1'b0;
                bus.frame_err  <= 1'b0;
            end
            if (state == IDLE) begin
                div       <= '0;
                phase     <= '0;
                cnt       <= '0;
                ferr_pend <= 1'b0;
                if (rx_s && primed[1])
                    armed <= 1'b1;
                else if (!rx_s && armed)
                    state <= START;
            end else begin
                div <= tick ? '0 : div + 1'b1;
                if (tick)
                    phase <= wrap ? '0 : phase + 1'b1;
                if (tick && phase == PW'(M - 1))
                    smp_a <= rx_s;
                if (tick && phase == PW'(M))
                    smp_b <= rx_s;
                case (state)
                    START: begin
                        if (decide && maj)
                            state <= IDLE;
                        else if (wrap)
                            state <= DATA;
                    end
                    DATA: begin
                        if (decide) begin
                            shreg <= {maj, shreg[DATA_BITS-1:1]};
                            cnt   <= cnt + 1'b1;
                        end
                        if (wrap && cnt == 4'(DATA_BITS)) begin
                            cnt   <= '0;
                            state <= PARITY != 0 ? PAR : STOP;
                        end
                    end
                    PAR: begin
                        if (decide)
                            par_bit <= maj;
                        if (wrap)
                            state <= STOP;
                    end
                    STOP: begin
                        if (decide) begin
                            ferr_pend <= fe;
                            if (cnt == 4'(STOP_BITS - 1)) begin
                                state <= IDLE;
                                armed <= rx_s;
                                if (!bus.valid || bus.ready) begin
                                    bus.data_out   <= shreg;
                                    bus.parity_err <= pe;
                                    bus.frame_err  <= fe;
                                    bus.valid      <= 1'b1;
                                    bus.overrun    <= 1'b0;
                                end else begin
                                    bus.overrun <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: directed checks of the oversampling UART receiver in 8N1, 8E1 and 8O1
module tb_uart_rx_oversample;
    localparam int B = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic ready = 1'b1;
    int errors = 0;
    int checks = 0;

    int cnt_n = 0, cnt_e = 0, cnt_o = 0;
    logic [7:0] cd_n = '0, cd_e = '0;
    logic cfe_n = 1'b0, cpe_e = 1'b0, cpe_o = 1'b0;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) if_n ();
    uart_rx_if #(.DATA_BITS(8)) if_e ();
    uart_rx_if #(.DATA_BITS(8)) if_o ();
    assign if_n.ready = ready;
    assign if_e.ready = ready;
    assign if_o.ready = ready;

    uart_rx_oversample #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_n (.clk(clk), .rst(rst), .rx(rx), .bus(if_n));
    uart_rx_oversample #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
        dut_e (.clk(clk), .rst(rst), .rx(rx), .bus(if_e));
    uart_rx_oversample #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
        dut_o (.clk(clk), .rst(rst), .rx(rx), .bus(if_o));

    // record every completed transfer on each receiver
    always @(negedge clk) begin
        if (if_n.valid && if_n.ready) begin
            cnt_n <= cnt_n + 1;
            cd_n  <= if_n.data_out;
            cfe_n <= if_n.frame_err;
        end
        if (if_e.valid && if_e.ready) begin
            cnt_e <= cnt_e + 1;
            cd_e  <= if_e.data_out;
            cpe_e <= if_e.parity_err;
        end
        if (if_o.valid && if_o.ready) begin
            cnt_o <= cnt_o + 1;
            cpe_o <= if_o.parity_err;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] f, input int nb, input int gbit);
        for (int i = 0; i < nb; i++) begin
            rx = f[i];
            if (i == gbit) begin
                cyc(34);
                rx = ~f[i];
                cyc(4);
                rx = f[i];
                cyc(26);
            end else begin
                cyc(B);
            end
        end
        rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        cyc(3);
        checks++;
        if ({if_n.valid, if_n.parity_err, if_n.frame_err, if_n.overrun, if_n.busy} !== 5'b0 || if_n.data_out !== 8'h00)
            $display("FAIL reset_outputs: got v=%0b pe=%0b fe=%0b ov=%0b busy=%0b data=%h, want all 0",
                     if_n.valid, if_n.parity_err, if_n.frame_err, if_n.overrun, if_n.busy, if_n.data_out);
        if ({if_n.valid, if_n.parity_err, if_n.frame_err, if_n.overrun, if_n.busy} !== 5'b0 || if_n.data_out !== 8'h00)
            errors++;
        rst = 1'b0;
        cyc(10);
    endtask

    task automatic test_basic;
        logic [9:0] f;
        f = {1'b1, 8'hA5, 1'b0};
        for (int c = 0; c < 700; c++) begin
            rx = c < 640 ? f[c / B] : 1'b1;
            cyc(1);
            if (c == 1) begin
                checks++;
                if (if_n.busy !== 1'b0) begin errors++; $display("FAIL busy_before_t0: got %0b want 0", if_n.busy); end
            end
            if (c == 2) begin
                checks++;
                if (if_n.busy !== 1'b1) begin errors++; $display("FAIL busy_at_t0p1: got %0b want 1", if_n.busy); end
            end
            if (c == 617) begin
                checks++;
                if (if_n.valid !== 1'b0 || if_n.busy !== 1'b1) begin
                    errors++; $display("FAIL basic_pre_commit: got valid=%0b busy=%0b want 0/1", if_n.valid, if_n.busy);
                end
            end
            if (c == 618) begin
                checks++;
                if (if_n.valid !== 1'b1 || if_n.data_out !== 8'hA5 || if_n.busy !== 1'b0) begin
                    errors++; $display("FAIL basic_valid: got valid=%0b data=%h busy=%0b want 1/a5/0", if_n.valid, if_n.data_out, if_n.busy);
                end
                checks++;
                if (if_n.parity_err !== 1'b0 || if_n.frame_err !== 1'b0 || if_n.overrun !== 1'b0) begin
                    errors++; $display("FAIL basic_flags: got pe=%0b fe=%0b ov=%0b want 0", if_n.parity_err, if_n.frame_err, if_n.overrun);
                end
            end
            if (c == 619) begin
                checks++;
                if (if_n.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_fall: got %0b want 0", if_n.valid); end
            end
        end
        cyc(2 * B);
    endtask

    task automatic test_parity;
        int ne, no;
        ne = cnt_e;
        no = cnt_o;
        send(12'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, -1);
        cyc(20);
        checks++;
        if (cnt_e !== ne + 1 || cd_e !== 8'h3C || cpe_e !== 1'b0) begin
            errors++; $display("FAIL even_par0: got n=%0d data=%h pe=%0b want %0d/3c/0", cnt_e, cd_e, cpe_e, ne + 1);
        end
        checks++;
        if (cnt_o !== no + 1 || cpe_o !== 1'b1) begin
            errors++; $display("FAIL odd_par0: got n=%0d pe=%0b want %0d/1", cnt_o, cpe_o, no + 1);
        end
        cyc(2 * B);
        send(12'({1'b1, 1'b1, 8'h3C, 1'b0}), 11, -1);
        cyc(20);
        checks++;
        if (cnt_e !== ne + 2 || cd_e !== 8'h3C || cpe_e !== 1'b1) begin
            errors++; $display("FAIL even_par1: got n=%0d data=%h pe=%0b want %0d/3c/1", cnt_e, cd_e, cpe_e, ne + 2);
        end
        checks++;
        if (cnt_o !== no + 2 || cpe_o !== 1'b0) begin
            errors++; $display("FAIL odd_par1: got n=%0d pe=%0b want %0d/0", cnt_o, cpe_o, no + 2);
        end
        cyc(2 * B);
    endtask

    task automatic test_glitch;
        int n0;
        n0 = cnt_n;
        rx = 1'b0;
        cyc(20);
        rx = 1'b1;
        checks++;
        if (if_n.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy: got %0b want 1", if_n.busy); end
        cyc(B);
        checks++;
        if (if_n.busy !== 1'b0 || if_n.valid !== 1'b0 || cnt_n !== n0) begin
            errors++; $display("FAIL glitch_reject: got busy=%0b valid=%0b n=%0d want 0/0/%0d", if_n.busy, if_n.valid, cnt_n, n0);
        end
        cyc(B);
    endtask

    task automatic test_vote;
        int n0;
        n0 = cnt_n;
        send(12'({1'b1, 8'hFF, 1'b0}), 10, 4);
        cyc(20);
        checks++;
        if (cnt_n !== n0 + 1 || cd_n !== 8'hFF || cfe_n !== 1'b0) begin
            errors++; $display("FAIL vote_ff: got n=%0d data=%h fe=%0b want %0d/ff/0", cnt_n, cd_n, cfe_n, n0 + 1);
        end
        cyc(2 * B);
        send(12'({1'b0, 8'h55, 1'b0}), 10, -1);
        cyc(20);
        checks++;
        if (cnt_n !== n0 + 2 || cd_n !== 8'h55 || cfe_n !== 1'b1) begin
            errors++; $display("FAIL stop_zero: got n=%0d data=%h fe=%0b want %0d/55/1", cnt_n, cd_n, cfe_n, n0 + 2);
        end
        cyc(2 * B);
    endtask

    task automatic test_overrun;
        ready = 1'b0;
        send(12'({1'b1, 8'h11, 1'b0}), 10, -1);
        cyc(10);
        send(12'({1'b1, 8'h22, 1'b0}), 10, -1);
        cyc(20);
        checks++;
        if (if_n.valid !== 1'b1 || if_n.data_out !== 8'h11 || if_n.overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_hold: got valid=%0b data=%h ov=%0b want 1/11/1", if_n.valid, if_n.data_out, if_n.overrun);
        end
        ready = 1'b1;
        cyc(1);
        checks++;
        if (if_n.valid !== 1'b0 || if_n.overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_accept: got valid=%0b ov=%0b want 0/0", if_n.valid, if_n.overrun);
        end
        ready = 1'b0;
        cyc(10);
        send(12'({1'b1, 8'h33, 1'b0}), 10, -1);
        cyc(20);
        checks++;
        if (if_n.valid !== 1'b1 || if_n.data_out !== 8'h33 || if_n.overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_clear: got valid=%0b data=%h ov=%0b want 1/33/0", if_n.valid, if_n.data_out, if_n.overrun);
        end
        ready = 1'b1;
        cyc(2 * B);
    endtask

    task automatic test_mid_reset;
        int n0;
        logic [9:0] f;
        ready = 1'b0;
        send(12'({1'b1, 8'h81, 1'b0}), 10, -1);
        cyc(20);
        checks++;
        if (if_n.valid !== 1'b1 || if_n.data_out !== 8'h81) begin
            errors++; $display("FAIL held_before_reset: got valid=%0b data=%h want 1/81", if_n.valid, if_n.data_out);
        end
        f = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx = f[i];
            cyc(B);
        end
        rx = f[4];
        cyc(30);
        checks++;
        if (if_n.busy !== 1'b1) begin errors++; $display("FAIL busy_mid_frame: got %0b want 1", if_n.busy); end
        rst = 1'b1;
        rx = 1'b0;
        cyc(2);
        checks++;
        if ({if_n.valid, if_n.parity_err, if_n.frame_err, if_n.overrun, if_n.busy} !== 5'b0 || if_n.data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_outputs: got v=%0b pe=%0b fe=%0b ov=%0b busy=%0b data=%h, want all 0",
                     if_n.valid, if_n.parity_err, if_n.frame_err, if_n.overrun, if_n.busy, if_n.data_out);
        end
        rst = 1'b0;
        ready = 1'b1;
        n0 = cnt_n;
        cyc(11 * B);
        checks++;
        if (if_n.valid !== 1'b0 || if_n.busy !== 1'b0 || cnt_n !== n0) begin
            errors++; $display("FAIL low_after_reset: got valid=%0b busy=%0b n=%0d want 0/0/%0d", if_n.valid, if_n.busy, cnt_n, n0);
        end
        rx = 1'b1;
        cyc(20);
        send(12'({1'b1, 8'h5A, 1'b0}), 10, -1);
        cyc(20);
        checks++;
        if (cnt_n !== n0 + 1 || cd_n !== 8'h5A) begin
            errors++; $display("FAIL after_reset_rx: got n=%0d data=%h want %0d/5a", cnt_n, cd_n, n0 + 1);
        end
        cyc(B);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_vote();
        test_overrun();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_oversample.md
# uart_rx_oversample

Parametrised UART receiver for the FPGA top level. It replaces the single-sample receiver with several additions: 2-flop input synchronisation, configurable oversampling with 3-sample majority voting, and selectable frame format (data bits, none/even/odd parity, 1 or 2 stop bits). It also adds a valid/ready output handshake with parity, framing and overrun flags. It sits between the board `rx` pin and any byte consumer (FIFO, command parser, LED debug).

## Interface
- `CLK_DIV`, default 8: clk cycles per oversample tick; legal range ≥1.
- `OVERSAMPLE`, default 16: ticks per bit; even, ≥8.
- `DATA_BITS`, default 8: data bits per frame, 5–9.
- `PARITY`, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  asynchronous serial line; idle high.
- `data_out`  out  DATA_BITS  received word, LSB = first data bit.
- `valid`  out  1  `data_out` and flags hold a frame.
- `ready`  in  1  consumer accepts; a transfer occurs when `valid && ready` at a clk edge.
- `parity_err`  out  1  held frame failed the parity check; always 0 when PARITY=0.
- `frame_err`  out  1  a stop bit of the held frame sampled 0.
- `overrun`  out  1  one or more frames were dropped while `valid` was held.
- `busy`  out  1  FSM is not in IDLE.

## Operation
- **Synchroniser:** `rx` passes through 2 flops to give `rx_s`; both flops reset to 1.
- **Oversample divider:**
  - Counts 0..CLK_DIV-1 and pulses `tick` when it wraps.
  - Cleared in the cycle a start edge is detected, so bit phase is aligned to the edge.
  - Holds at 0 in IDLE.
- **Bit-phase counter:** 0..OVERSAMPLE-1, advanced on each tick.
  - Samples are taken at phases M-1, M and M+1, with M = OVERSAMPLE/2.
  - The bit value is the majority of the 3 samples, decided at phase M+1.
- **FSM:**
  - **IDLE:** sets `armed` once `rx_s`=1 has been seen. `armed && rx_s==0` goes to START.
  - **START:** majority 1 is a false start; return to IDLE with `armed` kept set. Majority 0 goes to DATA at phase wrap.
  - **DATA:** shift bits in LSB first. After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
  - **PARITY:** store the parity bit, then go to STOP.
  - **STOP:** sample STOP_BITS bits; any 0 sets the pending frame error. The commit happens at the decision of the last stop bit.
  - After commit: IDLE with `armed`=`rx_s`. A break (line held low) therefore cannot retrigger until the line returns high.
- **Parity check:**
  - Even: error if the parity bit ≠ XOR of the data bits.
  - Odd: error if the parity bit ≠ XNOR of the data bits.
- **Commit:**
  - If `valid`=0, or `valid && ready` in the same cycle: load `data_out`, `parity_err` and `frame_err`, set `valid`=1, clear `overrun`.
  - Else: drop the new frame, set `overrun`=1, leave the held data and flags unchanged.
- **Handshake:** on `valid && ready` with no simultaneous commit, `valid`, `overrun`, `parity_err` and `frame_err` all go to 0. `data_out` keeps its last value.
- **Reset values:** all outputs are 0. FSM = IDLE, `armed`=0, counters 0, synchroniser = 1.
- **Reset mid-frame:** the frame is abandoned with no commit. After reset, `rx` must be high for ≥1 synchronised cycle before a new start is accepted.

## Timing
- Bit period: B = CLK_DIV·OVERSAMPLE clk cycles.
- Synchroniser latency: 2 cycles from a `rx` change to `rx_s`.
- Start detection: the cycle in which `rx_s` first reads 0 while armed (t0).
- Majority decision for frame bit n (n=0 is start): (n·OVERSAMPLE + M + 2)·CLK_DIV clk cycles after t0.
- `valid` rises one cycle after the decision of the last stop bit.
- `valid` falls one cycle after the clk edge with `ready`=1.
- `busy` is 1 from t0+1 until the commit cycle (inclusive); it drops to 0 the cycle after.
- No minimum gap between frames: a new start can be detected in the cycle after commit, if armed.

## Test plan
- CLK_DIV=4, OVERSAMPLE=16, 8N1, `ready`=1, send 0xA5 → `valid` pulses 1 cycle with `data_out`=0xA5, both error flags 0, at t0+(9·16+10)·4+1.
- 8E1: send 0x3C with parity 0 → `parity_err`=0. Send 0x3C with parity 1 → `parity_err`=1 and `data_out`=0x3C. For 8O1, the parity values flip.
- `rx` low glitch of 20 clk cycles (< M ticks) in idle → no `valid`, `busy` returns to 0 within B cycles.
- Single-tick glitch at a data-bit centre (phase M) of 0xFF → majority vote keeps `data_out`=0xFF. Stop bit forced 0 → `frame_err`=1.
- `ready`=0, send 0x11 then 0x22 → `data_out`=0x11, `overrun`=1. Raise `ready` → `valid`=0. Next frame 0x33 → `overrun`=0.
- Assert `rst` during DATA bit 3 → all outputs 0. Line held low after reset → no `valid`. Then idle high and send 0x5A → 0x5A received.
